// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The master side is the control unit; the slave side is the datapath.
interface multicycle_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic             zero;
    logic [3:0]       CurState;
    logic             PCWre;
    logic             IRWre;
    logic [1:0]       ExtSel;
    logic             ALUSrcA;
    logic             ALUSrcB;
    logic [2:0]       ALUOp;
    logic             RegDst;
    logic             WrRegDSrc;
    logic             RegWre;
    logic             mRD;
    logic             mWR;
    logic [1:0]       PCSrc;
    logic             Halted;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        input  op, zero,
        output CurState, PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB,
        output ALUOp, RegDst, WrRegDSrc, RegWre, mRD, mWR, PCSrc,
        output Halted, InstrCount
    );

    modport slave (
        output op, zero,
        input  CurState, PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB,
        input  ALUOp, RegDst, WrRegDSrc, RegWre, mRD, mWR, PCSrc,
        input  Halted, InstrCount
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the MIPS-subset core: IF/ID/EXE/MEM/WB
// sequencing, datapath enables/selects and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int CNT_W = 32
) (
    input logic                 CLK,
    input logic                 Reset,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [3:0] {
        stIf    = 4'b0000,
        stId    = 4'b0001,
        stExeAl = 4'b0010,
        stWbAl  = 4'b0011,
        stExeLs = 4'b0100,
        stMem   = 4'b0101,
        stWbL   = 4'b0110,
        stExeBr = 4'b0111,
        stHalt  = 4'b1000
    } state_t;

    localparam logic [5:0] opAdd  = 6'b000000;
    localparam logic [5:0] opSub  = 6'b000001;
    localparam logic [5:0] opAddi = 6'b000010;
    localparam logic [5:0] opOr   = 6'b010000;
    localparam logic [5:0] opAnd  = 6'b010001;
    localparam logic [5:0] opOri  = 6'b010010;
    localparam logic [5:0] opSll  = 6'b011000;
    localparam logic [5:0] opSlt  = 6'b100110;
    localparam logic [5:0] opSw   = 6'b110000;
    localparam logic [5:0] opLw   = 6'b110001;
    localparam logic [5:0] opBeq  = 6'b110100;
    localparam logic [5:0] opJ    = 6'b111000;
    localparam logic [5:0] opHalt = 6'b111111;

    state_t state, nextState;
    logic [CNT_W-1:0] count;
    logic isR, isAlu, isLw, isSw, isBeq, isJ, isHalt, isIllegal;
    logic active, pcWre;

    always_comb begin
        isR = (bus.op == opAdd) || (bus.op == opSub) ||
              (bus.op == opOr)  || (bus.op == opAnd) ||
              (bus.op == opSll) || (bus.op == opSlt);
        isAlu  = isR || (bus.op == opAddi) || (bus.op == opOri);
        isLw   = (bus.op == opLw);
        isSw   = (bus.op == opSw);
        isBeq  = (bus.op == opBeq);
        isJ    = (bus.op == opJ);
        isHalt = (bus.op == opHalt);
        isIllegal = !(isAlu || isLw || isSw || isBeq || isJ || isHalt);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= stIf;
        else       state <= nextState;
    end

    always_comb begin
        nextState = stIf;
        case (state)
            stIf: nextState = stId;
            stId: begin
                unique case (1'b1)
                    isAlu:        nextState = stExeAl;
                    isLw || isSw: nextState = stExeLs;
                    isBeq:        nextState = stExeBr;
                    isHalt:       nextState = stHalt;
                    default:      nextState = stIf;
                endcase
            end
            stExeAl: nextState = stWbAl;
            stWbAl:  nextState = stIf;
            stExeLs: nextState = stMem;
            stMem:   nextState = isLw ? stWbL : stIf;
            stWbL:   nextState = stIf;
            stExeBr: nextState = stIf;
            stHalt:  nextState = stHalt;
            default: nextState = stIf;
        endcase
    end

    // Decode-driven selects stay stable from ID until the instruction ends.
    always_comb begin
        active = (state != stIf) && (state != stHalt);
        pcWre = 1'b0;
        bus.PCSrc = 2'b00;
        bus.ExtSel = 2'b00;
        bus.ALUOp = 3'b000;
        bus.ALUSrcA = 1'b0;
        bus.ALUSrcB = 1'b0;
        bus.RegDst = 1'b0;
        if (active) begin
            case (bus.op)
                opSll:   bus.ExtSel = 2'b00;
                opOri:   bus.ExtSel = 2'b01;
                default: bus.ExtSel = 2'b10;
            endcase
            case (bus.op)
                opSub, opBeq: bus.ALUOp = 3'b001;
                opSll:        bus.ALUOp = 3'b010;
                opOr, opOri:  bus.ALUOp = 3'b011;
                opAnd:        bus.ALUOp = 3'b100;
                opSlt:        bus.ALUOp = 3'b101;
                default:      bus.ALUOp = 3'b000;
            endcase
            bus.ALUSrcA = (bus.op == opSll);
            bus.ALUSrcB = (bus.op == opAddi) || (bus.op == opOri) ||
                          isLw || isSw;
            bus.RegDst = isR;
        end
        case (state)
            stId: begin
                pcWre = isJ || isIllegal;
                if (isJ) bus.PCSrc = 2'b11;
            end
            stWbAl:  pcWre = 1'b1;
            stWbL:   pcWre = 1'b1;
            stMem:   pcWre = !isLw;
            stExeBr: begin
                pcWre = 1'b1;
                if (bus.zero) bus.PCSrc = 2'b01;
            end
            default: pcWre = 1'b0;
        endcase
    end

    // Write strobes are squashed combinationally so reset aborts instantly.
    assign bus.PCWre     = pcWre & ~Reset;
    assign bus.IRWre     = (state == stIf) & ~Reset;
    assign bus.RegWre    = ((state == stWbAl) || (state == stWbL)) & ~Reset;
    assign bus.mWR       = (state == stMem) & isSw & ~Reset;
    assign bus.mRD       = (state == stMem) & isLw;
    assign bus.WrRegDSrc = (state == stWbL);
    assign bus.Halted    = (state == stHalt);
    assign bus.CurState  = state;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)          count <= '0;
        else if (bus.PCWre) count <= count + CNT_W'(1);
    end

    assign bus.InstrCount = count;
endmodule
